// File: rtl/score_digits_renderer_pkg.sv
// Shared bitmap geometry and BCD types for the score digit renderer.
package score_digits_renderer_pkg;
  localparam int DIGIT_W     = 5;
  localparam int DIGIT_H     = 5;
  localparam int DIGIT_PITCH = 6;
  localparam int NUM_DIGITS  = 2;

  typedef logic [3:0] bcd_t;
endpackage

// File: rtl/score_digits_renderer_bcd_counter2.sv
// Two-digit BCD score counter; clear wins over increment.
// Latency: score/overflow registered, visible one cycle after the pulse.
// Backpressure: none, every pulse is applied in the cycle it is seen.
module bcd_counter2
  import score_digits_renderer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] score,
  output logic       overflow
);

  bcd_t tens;
  bcd_t ones;

  always_ff @(posedge clk) begin
    overflow <= 1'b0;
    if (reset || clr) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc) begin
      if (ones != 4'd9) begin
        ones <= ones + 4'd1;
      end else begin
        ones <= 4'd0;
        // Carry out of the tens digit wraps 99 -> 00 and flags it once.
        if (tens != 4'd9) begin
          tens <= tens + 4'd1;
        end else begin
          tens     <= 4'd0;
          overflow <= 1'b1;
        end
      end
    end
  end

  assign score = {tens, ones};

endmodule

// File: rtl/score_digits_renderer.sv
// Scans a 2-digit BCD score onto the raster through an external digit ROM.
// Latency: ROM address combinational from hpos/vpos, pixel registered (1 cycle).
// Backpressure: none, follows the sync generator every pixel clock.
module score_digits_renderer
  import score_digits_renderer_pkg::*;
#(
  parameter int X0         = 16,
  parameter int Y0         = 16,
  parameter int SCALE_LOG2 = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic       display_on,
  input  logic       score_inc,
  input  logic       score_clr,
  output logic [3:0] digit,
  output logic [2:0] yofs,
  input  logic [4:0] bits,
  output logic [7:0] score,
  output logic       overflow,
  output logic       pixel
);

  localparam int CELL = 1 << SCALE_LOG2;
  localparam logic [9:0] X_BEG = 10'(X0);
  localparam logic [9:0] X_END = 10'(X0 + DIGIT_PITCH * NUM_DIGITS * CELL);
  localparam logic [9:0] Y_BEG = 10'(Y0);
  localparam logic [9:0] Y_END = 10'(Y0 + DIGIT_H * CELL);

  logic [7:0] disp_score;
  logic [8:0] relx, rely;
  logic [3:0] col;
  logic [2:0] row, xofs;
  logic       in_box, tens_sel, pix_next;
  bcd_t       nib;
  logic [4:0] bits_shl;

  bcd_counter2 u_counter (
    .clk      (clk),
    .reset    (reset),
    .inc      (score_inc),
    .clr      (score_clr),
    .score    (score),
    .overflow (overflow)
  );

  always_comb begin
    relx     = hpos - X_BEG[8:0];
    rely     = vpos - Y_BEG[8:0];
    col      = 4'(relx >> SCALE_LOG2);
    row      = 3'(rely >> SCALE_LOG2);
    in_box   = ({1'b0, hpos} >= X_BEG) && ({1'b0, hpos} < X_END) &&
               ({1'b0, vpos} >= Y_BEG) && ({1'b0, vpos} < Y_END);
    tens_sel = (col < 4'd6);
    xofs     = tens_sel ? col[2:0] : 3'(col - 4'd6);
    nib      = tens_sel ? disp_score[7:4] : disp_score[3:0];
    digit    = in_box ? nib : 4'd0;
    yofs     = in_box ? row : 3'd0;
    // Shifting the row left by xofs puts column xofs at bit 4; the spacer
    // column (xofs >= 5) shifts everything out and reads as 0.
    bits_shl = bits << xofs;
    pix_next = display_on & in_box & bits_shl[4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel      <= 1'b0;
      disp_score <= 8'h00;
    end else begin
      pixel <= pix_next;
      // Latch the score only at frame start so a frame never mixes values.
      if (hpos == 9'd0 && vpos == 9'd0)
        disp_score <= score;
    end
  end

endmodule

// File: tb/tb_score_digits_renderer.sv
// Self-checking bench for score_digits_renderer with a behavioural digit ROM.
module tb_score_digits_renderer;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] hpos, vpos;
  logic       display_on, score_inc, score_clr;
  logic [3:0] digit;
  logic [2:0] yofs;
  logic [4:0] bits;
  logic [7:0] score;
  logic       overflow, pixel;

  int checks = 0;
  int fails  = 0;
  logic exp_q[$];

  typedef struct {
    int   h;
    int   v;
    logic de;
    logic exp;
  } vec_t;

  always #5 clk = ~clk;

  score_digits_renderer #(.X0(16), .Y0(16), .SCALE_LOG2(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .score_inc  (score_inc),
    .score_clr  (score_clr),
    .digit      (digit),
    .yofs       (yofs),
    .bits       (bits),
    .score      (score),
    .overflow   (overflow),
    .pixel      (pixel)
  );

  function automatic logic [4:0] font(input logic [3:0] d, input logic [2:0] y);
    logic [24:0] g;
    case (d)
      4'd0: g = 25'b11111_10001_10001_10001_11111;
      4'd1: g = 25'b01100_00100_00100_00100_01110;
      4'd2: g = 25'b11111_00001_11111_10000_11111;
      4'd3: g = 25'b11111_00001_01111_00001_11111;
      4'd4: g = 25'b10001_10001_11111_00001_00001;
      4'd5: g = 25'b11111_10000_11111_00001_11111;
      4'd6: g = 25'b11111_10000_11111_10001_11111;
      4'd7: g = 25'b11111_00001_00001_00001_00001;
      4'd8: g = 25'b11111_10001_11111_10001_11111;
      4'd9: g = 25'b11111_10001_11111_00001_11111;
      default: g = 25'd0;
    endcase
    if (y > 3'd4) return 5'd0;
    return g[24 - 5*int'(y) -: 5];
  endfunction

  assign bits = font(digit, yofs);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic px(input int h, input int v, input logic de, input logic exp);
    logic e;
    hpos = 9'(h);
    vpos = 9'(v);
    display_on = de;
    exp_q.push_back(exp);
    tick();
    e = exp_q.pop_front();
    chk($sformatf("pixel h=%0d v=%0d de=%0b", h, v, de), {31'd0, pixel}, {31'd0, e});
  endtask

  task automatic pulse_inc;
    hpos = 9'd400;
    vpos = 9'd400;
    score_inc = 1'b1;
    tick();
    score_inc = 1'b0;
  endtask

  task automatic run_table(input vec_t t[]);
    foreach (t[i]) px(t[i].h, t[i].v, t[i].de, t[i].exp);
  endtask

  initial begin
    vec_t frame00[];
    vec_t frame10[];
    frame00 = '{
      '{16, 16, 1'b1, 1'b1}, '{23, 16, 1'b1, 1'b1}, '{15, 16, 1'b1, 1'b0},
      '{56, 16, 1'b1, 1'b0}, '{63, 16, 1'b1, 1'b0}, '{64, 16, 1'b1, 1'b1},
      '{103, 16, 1'b1, 1'b1}, '{104, 16, 1'b1, 1'b0}, '{112, 16, 1'b1, 1'b0},
      '{16, 24, 1'b1, 1'b1}, '{40, 24, 1'b1, 1'b0}, '{48, 24, 1'b1, 1'b1},
      '{16, 55, 1'b1, 1'b1}, '{16, 56, 1'b1, 1'b0}, '{16, 15, 1'b1, 1'b0},
      '{20, 16, 1'b0, 1'b0}
    };
    frame10 = '{
      '{16, 16, 1'b1, 1'b0}, '{23, 16, 1'b1, 1'b0}, '{24, 16, 1'b1, 1'b1},
      '{39, 16, 1'b1, 1'b1}, '{40, 16, 1'b1, 1'b0}, '{55, 16, 1'b1, 1'b0},
      '{64, 16, 1'b1, 1'b1}, '{16, 48, 1'b1, 1'b0}, '{24, 48, 1'b1, 1'b1}
    };

    reset = 1'b1; hpos = 9'd0; vpos = 9'd0;
    display_on = 1'b0; score_inc = 1'b0; score_clr = 1'b0;
    tick(); tick();
    chk("reset score", {24'd0, score}, 32'h00);
    chk("reset overflow", {31'd0, overflow}, 32'd0);
    chk("reset pixel", {31'd0, pixel}, 32'd0);
    reset = 1'b0;

    px(0, 0, 1'b1, 1'b0);
    run_table(frame00);

    for (int i = 0; i < 10; i++) pulse_inc();
    chk("score after 10 inc", {24'd0, score}, 32'h10);
    px(0, 0, 1'b1, 1'b0);
    run_table(frame10);

    score_clr = 1'b1; tick(); score_clr = 1'b0;
    chk("clr score", {24'd0, score}, 32'h00);
    for (int i = 0; i < 100; i++) begin
      pulse_inc();
      chk($sformatf("overflow pulse %0d", i + 1), {31'd0, overflow}, {31'd0, i == 99});
    end
    tick();
    chk("overflow after wrap", {31'd0, overflow}, 32'd0);
    chk("score after 100 inc", {24'd0, score}, 32'h00);

    for (int i = 0; i < 45; i++) pulse_inc();
    chk("score 45", {24'd0, score}, 32'h45);
    score_inc = 1'b1; score_clr = 1'b1; tick();
    score_inc = 1'b0; score_clr = 1'b0;
    chk("inc+clr score", {24'd0, score}, 32'h00);
    chk("inc+clr overflow", {31'd0, overflow}, 32'd0);

    px(0, 0, 1'b1, 1'b0);
    px(64, 16, 1'b1, 1'b1);
    hpos = 9'd20; vpos = 9'd30;
    score_inc = 1'b1; tick(); score_inc = 1'b0;
    chk("mid-frame inc score", {24'd0, score}, 32'h01);
    px(64, 16, 1'b1, 1'b1);
    score_inc = 1'b1;
    px(0, 0, 1'b1, 1'b0);
    score_inc = 1'b0;
    chk("frame-start inc score", {24'd0, score}, 32'h02);
    px(64, 16, 1'b1, 1'b0);
    px(72, 16, 1'b1, 1'b1);
    px(0, 0, 1'b1, 1'b0);
    px(64, 16, 1'b1, 1'b1);
    px(72, 32, 1'b1, 1'b1);

    hpos = 9'd72; vpos = 9'd40; #1;
    chk("rom digit ones", {28'd0, digit}, 32'd2);
    chk("rom yofs ones", {29'd0, yofs}, 32'd3);
    hpos = 9'd24; #1;
    chk("rom digit tens", {28'd0, digit}, 32'd0);
    hpos = 9'd16; vpos = 9'd56; #1;
    chk("rom yofs outside", {29'd0, yofs}, 32'd0);
    hpos = 9'd72; vpos = 9'd40; #1;
    chk("rom digit in box", {28'd0, digit}, 32'd2);
    hpos = 9'd200; vpos = 9'd200; #1;
    chk("rom digit outside", {28'd0, digit}, 32'd0);

    px(20, 17, 1'b1, 1'b1);
    reset = 1'b1;
    px(20, 17, 1'b1, 1'b0);
    reset = 1'b0;
    chk("mid-frame reset score", {24'd0, score}, 32'h00);
    chk("mid-frame reset disp", {24'd0, dut.disp_score}, 32'h00);
    chk("mid-frame reset overflow", {31'd0, overflow}, 32'd0);
    px(72, 32, 1'b1, 1'b0);
    px(64, 32, 1'b1, 1'b1);
    px(20, 17, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
